// File: rtl/rp_heater_ctrl.sv
// Ring-oscillator bank heater: staggered ramp, PWM gating, burst timer, status register.
// reg_0 commands act on the second Clk edge after they change; osc_en is registered; no backpressure.
module rp_heater_ctrl #(
    parameter int NUM_BANKS   = 8,
    parameter int PWM_BITS    = 8,
    parameter int RAMP_CYCLES = 16,
    parameter int BURST_BITS  = 24,
    parameter int ELAP_BITS   = 24
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [31:0]           reg_0,
    input  logic [NUM_BANKS-1:0]  bank_mask,
    input  logic [BURST_BITS-1:0] burst_len,
    output logic [31:0]           reg_1,
    output logic [NUM_BANKS-1:0]  osc_en
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int RC_W = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RAMP_CYCLES - 1);

    state_t                st, st_d;
    logic                  start_q, stop_q, clr_q, mode_in_q;
    logic                  start_qq, stop_qq, clr_qq;
    logic [PWM_BITS-1:0]   duty_in, duty_q, duty_d;
    logic                  start_e, stop_e, clr_e;
    logic [NUM_BANKS-1:0]  active, active_d, mask_q;
    logic                  mode_q;
    logic [BURST_BITS-1:0] blen_q, burst_cnt, burst_d;
    logic [RC_W-1:0]       ramp_cnt, ramp_d;
    logic [ELAP_BITS-1:0]  elapsed, elapsed_d;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic                  err, err_d;
    logic                  enter, set_err;
    logic                  busy, busy_d, burst_hit, gate;
    logic [NUM_BANKS-1:0]  osc_d;
    logic [31:0]           elap_sh;
    logic [15:0]           elap_field;
    logic                  unused_bits;

    assign unused_bits = ^{reg_0[31:8+PWM_BITS], reg_0[7:4]};

    function automatic logic [NUM_BANKS-1:0] lowest_bit(input logic [NUM_BANKS-1:0] v);
        return v & (~v + NUM_BANKS'(1));
    endfunction

    function automatic logic [4:0] popcount(input logic [NUM_BANKS-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < NUM_BANKS; i++) c = c + 5'(v[i]);
        return c;
    endfunction

    // Command bits pass through one register stage, then a second copy for edge detection.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            clr_q     <= 1'b0;
            mode_in_q <= 1'b0;
            duty_in   <= '0;
            start_qq  <= 1'b0;
            stop_qq   <= 1'b0;
            clr_qq    <= 1'b0;
        end else begin
            start_q   <= reg_0[0];
            stop_q    <= reg_0[1];
            clr_q     <= reg_0[3];
            mode_in_q <= reg_0[2];
            duty_in   <= reg_0[8 +: PWM_BITS];
            start_qq  <= start_q;
            stop_qq   <= stop_q;
            clr_qq    <= clr_q;
        end
    end

    assign start_e   = start_q & ~start_qq;
    assign stop_e    = stop_q & ~stop_qq;
    assign clr_e     = clr_q & ~clr_qq;
    assign busy      = (st == ST_RAMP) || (st == ST_RUN);
    // A zero burst length behaves like one: a single RAMP cycle, then DONE.
    assign burst_hit = mode_q && ((blen_q == '0) || (burst_cnt == blen_q - BURST_BITS'(1)));

    always_comb begin
        st_d      = st;
        active_d  = active;
        ramp_d    = ramp_cnt;
        burst_d   = burst_cnt;
        elapsed_d = elapsed;
        enter     = 1'b0;
        set_err   = 1'b0;

        case (st)
            ST_IDLE: begin
                if (start_e && !stop_e) begin
                    if (|bank_mask) enter = 1'b1;
                    else            set_err = 1'b1;
                end
            end
            ST_RAMP: begin
                if (stop_e)                  st_d = ST_IDLE;
                else if (burst_hit)          st_d = ST_DONE;
                else if (active == mask_q)   st_d = ST_RUN;
                else if (ramp_cnt == RC_LAST) begin
                    active_d = active | lowest_bit(mask_q & ~active);
                    ramp_d   = '0;
                end else begin
                    ramp_d = ramp_cnt + RC_W'(1);
                end
            end
            ST_RUN: begin
                if (stop_e)         st_d = ST_IDLE;
                else if (burst_hit) st_d = ST_DONE;
            end
            ST_DONE: begin
                if (stop_e || clr_e) st_d = ST_IDLE;
                else if (start_e) begin
                    if (|bank_mask) enter = 1'b1;
                    else            set_err = 1'b1;
                end
            end
            default: st_d = ST_IDLE;
        endcase

        if (busy) begin
            burst_d = burst_cnt + BURST_BITS'(1);
            if (~&elapsed) elapsed_d = elapsed + ELAP_BITS'(1);
        end

        if (enter) begin
            st_d      = ST_RAMP;
            active_d  = lowest_bit(bank_mask);
            ramp_d    = '0;
            burst_d   = '0;
            elapsed_d = '0;
        end

        busy_d = (st_d == ST_RAMP) || (st_d == ST_RUN);
        if (!busy_d) active_d = '0;

        duty_d = (enter || busy) ? duty_in : duty_q;
        gate   = (&duty_d) || (pwm_cnt < duty_d);
        osc_d  = (busy_d && gate) ? active_d : '0;

        err_d = err;
        if (clr_e)        err_d = 1'b0;
        else if (set_err) err_d = 1'b1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            st        <= ST_IDLE;
            active    <= '0;
            mask_q    <= '0;
            mode_q    <= 1'b0;
            blen_q    <= '0;
            duty_q    <= '0;
            burst_cnt <= '0;
            ramp_cnt  <= '0;
            elapsed   <= '0;
            pwm_cnt   <= '0;
            err       <= 1'b0;
            osc_en    <= '0;
        end else begin
            st        <= st_d;
            active    <= active_d;
            duty_q    <= duty_d;
            burst_cnt <= burst_d;
            ramp_cnt  <= ramp_d;
            elapsed   <= elapsed_d;
            pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
            err       <= err_d;
            osc_en    <= osc_d;
            if (enter) begin
                mask_q <= bank_mask;
                mode_q <= mode_in_q;
                blen_q <= burst_len;
            end
        end
    end

    assign elap_sh    = 32'(elapsed) >> 8;
    assign elap_field = ((&elapsed) || (elap_sh > 32'h0000_FFFF)) ? 16'hFFFF : elap_sh[15:0];

    always_comb begin
        reg_1        = '0;
        reg_1[0]     = busy;
        reg_1[1]     = (st == ST_DONE);
        reg_1[2]     = (st == ST_RAMP);
        reg_1[3]     = err;
        reg_1[12:8]  = popcount(active);
        reg_1[31:16] = elap_field;
    end

endmodule

// File: tb/tb_rp_heater_ctrl.sv
// Randomized bench for rp_heater_ctrl: timeline reference model feeds a queue, a negedge monitor checks every cycle.
module tb_rp_heater_ctrl;
    localparam int NB = 8;
    localparam int PB = 8;
    localparam int RC = 16;
    localparam int BB = 24;
    localparam int EB = 12;
    localparam int ELAP_MAX = (1 << EB) - 1;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic [31:0]   reg_0 = '0;
    logic [NB-1:0] bank_mask = '0;
    logic [BB-1:0] burst_len = '0;
    logic [31:0]   reg_1;
    logic [NB-1:0] osc_en;

    rp_heater_ctrl #(
        .NUM_BANKS(NB), .PWM_BITS(PB), .RAMP_CYCLES(RC), .BURST_BITS(BB), .ELAP_BITS(EB)
    ) dut (
        .Clk(Clk), .Reset(Reset), .reg_0(reg_0), .bank_mask(bank_mask),
        .burst_len(burst_len), .reg_1(reg_1), .osc_en(osc_en)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [7:0]  osc;
        logic [31:0] r1;
    } exp_t;
    exp_t expq[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    function automatic int popcnt(input logic [7:0] v);
        int c = 0;
        for (int i = 0; i < 8; i++) if (v[i]) c++;
        return c;
    endfunction

    // The k lowest set bits of m.
    function automatic logic [7:0] low_bits(input logic [7:0] m, input int k);
        logic [7:0] r = '0;
        int n = 0;
        for (int i = 0; i < 8; i++) begin
            if (m[i] && n < k) begin
                r[i] = 1'b1;
                n++;
            end
        end
        return r;
    endfunction

    function automatic int sat(input int k);
        return (k > ELAP_MAX) ? ELAP_MAX : k;
    endfunction

    // Model: state is a phase plus the edge index at which the ramp started; all timing derives from that.
    int          t, m_st, entry, m_blen, m_elap;
    logic [7:0]  m_mask;
    bit          m_mode, m_err;
    logic [31:0] h1, h2;

    always @(posedge Clk) begin
        int k, nb, added, ns, lim, elap;
        bit start, stop, clr, enter, set_err, nbusy, gate;
        logic [7:0] duty, pwm, act, oe;
        logic [31:0] r1;
        if (Reset) begin
            t = 0; m_st = 0; entry = 0; m_blen = 0; m_elap = 0;
            m_mask = '0; m_mode = 0; m_err = 0; h1 = '0; h2 = '0;
            expq.push_back('0);
        end else begin
            t++;
            start = h1[0] & ~h2[0];
            stop  = h1[1] & ~h2[1];
            clr   = h1[3] & ~h2[3];
            duty  = h1[15:8];
            pwm   = 8'((t - 1) % 256);
            ns = m_st; enter = 0; set_err = 0;
            if (m_st == 1 || m_st == 2) begin
                k   = t - entry;
                nb  = popcnt(m_mask);
                lim = (m_blen == 0) ? 1 : m_blen;
                if (stop) begin
                    ns = 0; m_elap = sat(k);
                end else if (m_mode && k >= lim) begin
                    ns = 3; m_elap = sat(k);
                end else begin
                    ns = (k > (nb - 1) * RC) ? 2 : 1;
                end
            end else if (m_st == 3 && (stop || clr)) begin
                ns = 0;
            end else if (start && !stop) begin
                if (bank_mask != 0) enter = 1;
                else                set_err = 1;
            end
            if (enter) begin
                ns = 1; entry = t; m_mask = bank_mask; m_mode = h1[2]; m_blen = int'(burst_len);
            end
            if (clr) m_err = 0;
            else if (set_err) m_err = 1;
            m_st = ns;
            nbusy = (ns == 1 || ns == 2);
            if (nbusy) begin
                k = t - entry;
                nb = popcnt(m_mask);
                added = 1 + k / RC;
                if (added > nb) added = nb;
                act = low_bits(m_mask, added);
                elap = sat(k);
            end else begin
                act = '0;
                elap = m_elap;
            end
            gate = (duty == 8'hFF) || (pwm < duty);
            oe = (nbusy && gate) ? act : 8'h00;
            r1 = '0;
            r1[0] = nbusy;
            r1[1] = (ns == 3);
            r1[2] = (ns == 1);
            r1[3] = m_err;
            r1[12:8] = 5'(popcnt(act));
            r1[31:16] = (elap >= ELAP_MAX) ? 16'hFFFF : 16'(elap >> 8);
            expq.push_back({oe, r1});
            h2 = h1;
            h1 = reg_0;
        end
    end

    always @(negedge Clk) begin
        exp_t e;
        if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL queue_underflow: no expectation at %0t", $time);
        end else begin
            e = expq.pop_front();
            if (Reset) begin
                check("osc_in_reset", 32'(osc_en), 32'h0);
                check("reg1_in_reset", reg_1, 32'h0);
            end else begin
                check("osc_en", 32'(osc_en), 32'(e.osc));
                check("reg_1", reg_1, e.r1);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    task automatic pulse(input logic [31:0] bits);
        reg_0 = reg_0 | bits;
        tick(1);
        reg_0 = reg_0 & ~bits;
        tick(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        int cnt;
        tick(3);
        Reset = 1'b0;
        tick(2);

        // Full ramp, continuous, full duty, then stop.
        bank_mask = 8'hFF; reg_0[15:8] = 8'hFF; reg_0[2] = 1'b0;
        pulse(32'h1);
        tick(130);
        pulse(32'h2);
        tick(3);

        // Partial duty, then duty 0 live.
        bank_mask = 8'h05; reg_0[15:8] = 8'h40;
        pulse(32'h1);
        tick(600);
        reg_0[15:8] = 8'h00;
        tick(300);
        pulse(32'h2);
        tick(3);

        // Burst of 100 cycles; independent enable-count check.
        bank_mask = 8'h01; burst_len = 24'd100; reg_0[2] = 1'b1; reg_0[15:8] = 8'hFF;
        pulse(32'h1);
        cnt = 0;
        repeat (150) begin
            @(negedge Clk);
            if (osc_en != 0) cnt++;
        end
        check("burst_enable_cycles", 32'(cnt), 32'd100);
        tick(1);
        pulse(32'h8);
        tick(3);
        pulse(32'h1);
        tick(130);
        burst_len = 24'd0;
        pulse(32'h1);
        tick(6);
        pulse(32'h8);
        tick(3);

        // Empty mask sets err; clr clears it.
        bank_mask = 8'h00; reg_0[2] = 1'b0;
        pulse(32'h1);
        tick(3);
        pulse(32'h8);
        tick(3);

        // start and stop together, then start during RUN.
        bank_mask = 8'hFF;
        pulse(32'h3);
        tick(3);
        pulse(32'h1);
        tick(150);
        pulse(32'h1);
        tick(20);
        pulse(32'h2);
        tick(3);

        // Asynchronous reset in the middle of a ramp.
        pulse(32'h1);
        tick(40);
        #1 Reset = 1'b1;
        reg_0 = '0;
        #1;
        check("async_reset_osc", 32'(osc_en), 32'h0);
        check("async_reset_reg1", reg_1, 32'h0);
        tick(2);
        Reset = 1'b0;
        tick(3);

        // Elapsed-time saturation on a long continuous run.
        bank_mask = 8'h81; reg_0[15:8] = 8'hFF; reg_0[2] = 1'b0;
        pulse(32'h1);
        tick(4500);
        check("elapsed_saturated", 32'(reg_1[31:16]), 32'h0000FFFF);
        pulse(32'h2);
        tick(3);

        // Randomized sessions.
        for (int i = 0; i < 12; i++) begin
            bank_mask = (i % 4 == 3) ? 8'h00 : 8'($urandom_range(1, 255));
            burst_len = 24'($urandom_range(0, 300));
            reg_0[2] = 1'($urandom_range(0, 1));
            reg_0[15:8] = 8'($urandom_range(0, 255));
            pulse(32'h1);
            tick(int'($urandom_range(30, 300)));
            reg_0[15:8] = 8'($urandom_range(0, 255));
            tick(int'($urandom_range(30, 300)));
            pulse(32'h2);
            pulse(32'h8);
            tick(2);
        end

        tick(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
